// File: rtl/elbeth_lsu_if.sv
// Request and memory-port signal bundle for elbeth_lsu.
// The slave modport is the LSU's view; the master modport drives requests and models the memory.
interface elbeth_lsu_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  lsu_valid;
   logic                  lsu_we;
   logic [1:0]            lsu_size;
   logic                  lsu_signed;
   logic [ADDR_WIDTH-1:0] lsu_addr;
   logic [31:0]           lsu_wdata;
   logic                  lsu_busy;
   logic                  lsu_done;
   logic [31:0]           lsu_rdata;
   logic                  lsu_misaligned;
   logic                  dmem_enable;
   logic [ADDR_WIDTH-1:0] dmem_addr;
   logic [31:0]           dmem_data_in;
   logic [3:0]            dmem_wr;
   logic [31:0]           dmem_data_out;
   logic                  dmem_ready;

   modport slave (
      input  lsu_valid, lsu_we, lsu_size, lsu_signed, lsu_addr, lsu_wdata,
      input  dmem_data_out, dmem_ready,
      output lsu_busy, lsu_done, lsu_rdata, lsu_misaligned,
      output dmem_enable, dmem_addr, dmem_data_in, dmem_wr
   );

   modport master (
      output lsu_valid, lsu_we, lsu_size, lsu_signed, lsu_addr, lsu_wdata,
      output dmem_data_out, dmem_ready,
      input  lsu_busy, lsu_done, lsu_rdata, lsu_misaligned,
      input  dmem_enable, dmem_addr, dmem_data_in, dmem_wr
   );
endinterface

// File: rtl/elbeth_lsu.sv
// Single-outstanding load/store unit for memory port B; ELBETH_LSU_MISALIGN_TRAP_EN traps misaligned half/word.
// Done pulses the edge after dmem_ready (min 2 edges); requests while busy are dropped, no queueing.
module elbeth_lsu #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   elbeth_lsu_if.slave bus
);
`ifdef ELBETH_LSU_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef enum logic {IDLE, ACCESS} state_t;

   typedef struct packed {
      logic       we;
      logic [1:0] size;
      logic       sgn;
      logic [1:0] lane;
   } req_t;

   state_t                state_q, state_d;
   req_t                  req_q, req_d;
   logic                  enable_q, enable_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [3:0]            wr_q, wr_d;
   logic [31:0]           wdat_q, wdat_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  done_q, done_d;
   logic                  mis_q, mis_d;

   logic                  is_byte, is_half, misaligned;
   logic [1:0]            lane;
   logic [3:0]            strobe;
   logic [31:0]           repl, shifted, loaded;

   // Request decode: half and word accesses fold onto their natural lane.
   always_comb begin
      is_byte    = (bus.lsu_size == 2'b00);
      is_half    = (bus.lsu_size == 2'b01);
      lane       = is_byte ? bus.lsu_addr[1:0] : (is_half ? {bus.lsu_addr[1], 1'b0} : 2'b00);
      misaligned = TRAP_EN && ((is_half && bus.lsu_addr[0]) ||
                               (!is_byte && !is_half && (bus.lsu_addr[1:0] != 2'b00)));
      strobe     = is_byte ? (4'b0001 << lane) : (is_half ? (4'b0011 << lane) : 4'b1111);
      repl       = is_byte ? {4{bus.lsu_wdata[7:0]}} :
                   (is_half ? {2{bus.lsu_wdata[15:0]}} : bus.lsu_wdata);
   end

   always_comb begin
      shifted = bus.dmem_data_out >> {req_q.lane, 3'b000};
      case (req_q.size)
         2'b00:   loaded = {{24{req_q.sgn & shifted[7]}}, shifted[7:0]};
         2'b01:   loaded = {{16{req_q.sgn & shifted[15]}}, shifted[15:0]};
         default: loaded = bus.dmem_data_out;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      enable_d = enable_q;
      addr_d   = addr_q;
      wr_d     = wr_q;
      wdat_d   = wdat_q;
      rdata_d  = rdata_q;
      done_d   = 1'b0;
      mis_d    = 1'b0;
      if (state_q == IDLE) begin
         if (bus.lsu_valid) begin
            req_d = '{we: bus.lsu_we, size: bus.lsu_size, sgn: bus.lsu_signed, lane: lane};
            if (misaligned) begin
               done_d = 1'b1;
               mis_d  = 1'b1;
            end else begin
               state_d  = ACCESS;
               enable_d = 1'b1;
               addr_d   = {bus.lsu_addr[ADDR_WIDTH-1:2], 2'b00};
               wr_d     = bus.lsu_we ? strobe : 4'b0000;
               wdat_d   = repl;
            end
         end
      end else if (bus.dmem_ready) begin
         state_d  = IDLE;
         enable_d = 1'b0;
         wr_d     = 4'b0000;
         done_d   = 1'b1;
         if (!req_q.we) rdata_d = loaded;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         req_q    <= '0;
         enable_q <= 1'b0;
         addr_q   <= '0;
         wr_q     <= 4'b0000;
         wdat_q   <= '0;
         rdata_q  <= '0;
         done_q   <= 1'b0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         enable_q <= enable_d;
         addr_q   <= addr_d;
         wr_q     <= wr_d;
         wdat_q   <= wdat_d;
         rdata_q  <= rdata_d;
         done_q   <= done_d;
         mis_q    <= mis_d;
      end
   end

   assign bus.lsu_busy       = (state_q == ACCESS);
   assign bus.lsu_done       = done_q;
   assign bus.lsu_rdata      = rdata_q;
   assign bus.lsu_misaligned = mis_q;
   assign bus.dmem_enable    = enable_q;
   assign bus.dmem_addr      = addr_q;
   assign bus.dmem_wr        = wr_q;
   assign bus.dmem_data_in   = wdat_q;
endmodule

// File: tb/tb_elbeth_lsu.sv
// Directed bench for elbeth_lsu: per-cycle compare against a transaction-level model plus literal pins.
module tb_elbeth_lsu;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   elbeth_lsu_if #(.ADDR_WIDTH(8)) bus ();
   elbeth_lsu #(.ADDR_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef ELBETH_LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   int vectors = 0;
   int miscompares = 0;

   logic        exp_busy, exp_en, exp_done, exp_mis, exp_store;
   logic [7:0]  exp_addr;
   logic [3:0]  exp_wr;
   logic [31:0] exp_din, exp_rdata;
   bit          chk_en = 1'b0;

   logic [7:0]  obs_addr;
   logic [3:0]  obs_wr;
   logic [31:0] obs_din;
   int          obs_edges, first_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic bit m_mis(input logic [1:0] size, input logic [7:0] addr);
      if (!TRAP) return 1'b0;
      if (size == 2'b01) return addr[0];
      if (size[1]) return (addr[1:0] != 2'b00);
      return 1'b0;
   endfunction

   function automatic logic [3:0] m_strobe(input bit we, input logic [1:0] size, input logic [7:0] addr);
      int a = int'(addr) % 4;
      if (!we) return 4'b0000;
      if (size == 2'b00) return 4'(1 << a);
      if (size == 2'b01) return 4'(3 << (a & 2));
      return 4'b1111;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
      if (size == 2'b00) return {4{wd[7:0]}};
      if (size == 2'b01) return {2{wd[15:0]}};
      return wd;
   endfunction

   function automatic logic [31:0] m_extract(input logic [31:0] w, input logic [1:0] size,
                                             input bit sgn, input logic [7:0] addr);
      int a = int'(addr) % 4;
      logic [31:0] v;
      if (size == 2'b00) begin
         v = (w >> (8 * a)) & 32'h0000_00FF;
         if (sgn && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2'b01) begin
         v = (w >> (8 * (a & 2))) & 32'h0000_FFFF;
         if (sgn && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 32'(bus.lsu_busy), 32'(exp_busy));
         chk("dmem_enable", 32'(bus.dmem_enable), 32'(exp_en));
         chk("done", 32'(bus.lsu_done), 32'(exp_done));
         chk("misaligned", 32'(bus.lsu_misaligned), 32'(exp_mis));
         chk("rdata", bus.lsu_rdata, exp_rdata);
         if (exp_en) begin
            chk("dmem_addr", 32'(bus.dmem_addr), 32'(exp_addr));
            chk("dmem_wr", 32'(bus.dmem_wr), 32'(exp_wr));
            if (exp_store) chk("dmem_data_in", bus.dmem_data_in, exp_din);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      obs_edges++;
      if (bus.lsu_done && first_done == 0) first_done = obs_edges;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         step();
         exp_done = 1'b0;
         exp_mis  = 1'b0;
      end
   endtask

   // Issues one request; returns #1 after the edge that should raise lsu_done.
   task automatic do_req(input bit we, input logic [1:0] size, input bit sgn, input logic [7:0] addr,
                         input logic [31:0] wd, input logic [31:0] mem, input int waits);
      bus.lsu_valid     = 1'b1;
      bus.lsu_we        = we;
      bus.lsu_size      = size;
      bus.lsu_signed    = sgn;
      bus.lsu_addr      = addr;
      bus.lsu_wdata     = wd;
      bus.dmem_data_out = mem;
      bus.dmem_ready    = (waits == 0);
      obs_edges = 0;
      first_done = 0;
      obs_addr = 8'h00;
      obs_wr = 4'h0;
      obs_din = 32'h0;
      step();
      bus.lsu_valid = 1'b0;
      exp_done = 1'b0;
      exp_mis  = 1'b0;
      if (m_mis(size, addr)) begin
         exp_done = 1'b1;
         exp_mis  = 1'b1;
         return;
      end
      exp_busy  = 1'b1;
      exp_en    = 1'b1;
      exp_store = we;
      exp_addr  = addr & 8'hFC;
      exp_wr    = m_strobe(we, size, addr);
      exp_din   = m_wdata(size, wd);
      obs_addr  = bus.dmem_addr;
      obs_wr    = bus.dmem_wr;
      obs_din   = bus.dmem_data_in;
      for (int i = 0; i < waits; i++) begin
         bus.lsu_valid = 1'b1;
         bus.lsu_we    = ~we;
         bus.lsu_addr  = addr ^ 8'h10;
         step();
      end
      bus.lsu_valid  = 1'b0;
      bus.dmem_ready = 1'b1;
      step();
      exp_busy = 1'b0;
      exp_en   = 1'b0;
      exp_done = 1'b1;
      if (!we) exp_rdata = m_extract(mem, size, sgn, addr);
   endtask

   initial begin
      rst = 1'b0;
      bus.lsu_valid = 1'b0;
      bus.lsu_we = 1'b0;
      bus.lsu_size = 2'b00;
      bus.lsu_signed = 1'b0;
      bus.lsu_addr = 8'h00;
      bus.lsu_wdata = 32'h0;
      bus.dmem_data_out = 32'h0;
      bus.dmem_ready = 1'b0;
      {exp_busy, exp_en, exp_done, exp_mis, exp_store} = 5'b0;
      exp_addr = 8'h00;
      exp_wr = 4'h0;
      exp_din = 32'h0;
      exp_rdata = 32'h0;
      chk_en = 1'b1;
      idle(3);
      chk("rst_enable", 32'(bus.dmem_enable), 32'h0);
      chk("rst_wr", 32'(bus.dmem_wr), 32'h0);
      chk("rst_addr", 32'(bus.dmem_addr), 32'h0);
      chk("rst_din", bus.dmem_data_in, 32'h0);
      chk("rst_busy", 32'(bus.lsu_busy), 32'h0);
      chk("rst_done", 32'(bus.lsu_done), 32'h0);
      chk("rst_rdata", bus.lsu_rdata, 32'h0);
      chk("rst_mis", 32'(bus.lsu_misaligned), 32'h0);
      rst = 1'b1;
      idle(2);

      // Word store with ready tied high, then a back-to-back byte store.
      do_req(1'b1, 2'b10, 1'b0, 8'h0C, 32'hDEADBEEF, 32'h0, 0);
      chk("sw_addr", 32'(obs_addr), 32'h0C);
      chk("sw_wr", 32'(obs_wr), 32'hF);
      chk("sw_din", obs_din, 32'hDEADBEEF);
      chk("sw_latency", first_done, 2);
      do_req(1'b1, 2'b00, 1'b0, 8'h09, 32'h0000_0008, 32'h0, 0);
      chk("sb_addr", 32'(obs_addr), 32'h08);
      chk("sb_wr", 32'(obs_wr), 32'h2);
      chk("sb_din", obs_din, 32'h08080808);
      idle(1);

      // Loads from word 0x80FF7F01, the last two back to back.
      do_req(1'b0, 2'b00, 1'b1, 8'h03, 32'h0, 32'h80FF7F01, 0);
      chk("lb_signed", bus.lsu_rdata, 32'hFFFFFF80);
      idle(1);
      do_req(1'b0, 2'b01, 1'b0, 8'h02, 32'h0, 32'h80FF7F01, 1);
      chk("lhu_hi", bus.lsu_rdata, 32'h000080FF);
      chk("ld_wr", 32'(obs_wr), 32'h0);
      do_req(1'b0, 2'b01, 1'b1, 8'h00, 32'h0, 32'h80FF7F01, 0);
      chk("lh_lo", bus.lsu_rdata, 32'h00007F01);
      idle(1);

      // Three wait states with an ignored request arriving while busy.
      do_req(1'b0, 2'b10, 1'b0, 8'h08, 32'h0, 32'h80FF7F01, 3);
      chk("wait_latency", first_done, 5);
      chk("wait_addr", 32'(obs_addr), 32'h08);
      chk("lw_wait", bus.lsu_rdata, 32'h80FF7F01);
      idle(2);

      do_req(1'b1, 2'b01, 1'b0, 8'h06, 32'h1234ABCD, 32'h0, 0);
      chk("sh_wr", 32'(obs_wr), 32'hC);
      chk("sh_din", obs_din, 32'hABCDABCD);
      idle(1);

      // Misaligned word load.
      do_req(1'b0, 2'b10, 1'b0, 8'h05, 32'h0, 32'hCAFEF00D, 0);
      if (TRAP) begin
         chk("trap_done", 32'(bus.lsu_done), 32'h1);
         chk("trap_mis", 32'(bus.lsu_misaligned), 32'h1);
         chk("trap_latency", first_done, 1);
         chk("trap_rdata", bus.lsu_rdata, 32'h80FF7F01);
      end else begin
         chk("mis_addr", 32'(obs_addr), 32'h04);
         chk("mis_flag", 32'(bus.lsu_misaligned), 32'h0);
         chk("mis_rdata", bus.lsu_rdata, 32'hCAFEF00D);
      end
      idle(2);

      do_req(1'b0, 2'b00, 1'b0, 8'h02, 32'h0, 32'h12345678, 0);
      chk("lbu", bus.lsu_rdata, 32'h00000034);
      idle(1);
      do_req(1'b0, 2'b11, 1'b1, 8'h00, 32'h0, 32'h87654321, 2);
      chk("size11", bus.lsu_rdata, 32'h87654321);
      idle(1);

      // Reset asserted while the memory is stalling.
      bus.lsu_valid = 1'b1;
      bus.lsu_we = 1'b1;
      bus.lsu_size = 2'b10;
      bus.lsu_addr = 8'h10;
      bus.lsu_wdata = 32'h5555AAAA;
      bus.dmem_ready = 1'b0;
      step();
      bus.lsu_valid = 1'b0;
      exp_busy = 1'b1;
      exp_en = 1'b1;
      exp_store = 1'b1;
      exp_addr = 8'h10;
      exp_wr = 4'hF;
      exp_din = 32'h5555AAAA;
      step();
      #2;
      rst = 1'b0;
      {exp_busy, exp_en, exp_done, exp_mis} = 4'b0;
      exp_rdata = 32'h0;
      #1;
      chk("arst_enable", 32'(bus.dmem_enable), 32'h0);
      chk("arst_wr", 32'(bus.dmem_wr), 32'h0);
      chk("arst_busy", 32'(bus.lsu_busy), 32'h0);
      chk("arst_rdata", bus.lsu_rdata, 32'h0);
      bus.dmem_ready = 1'b1;
      idle(2);
      rst = 1'b1;
      idle(1);
      do_req(1'b0, 2'b01, 1'b1, 8'h02, 32'h0, 32'h80010000, 1);
      chk("post_rst_lh", bus.lsu_rdata, 32'hFFFF8001);
      idle(2);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
